stream_demux_1ton: RTL and testbench

- Parametrised, registered successor to the team's combinational 1:4 demultiplexer.
- Routes a valid/ready input stream to one of NUM_CH output channels. Each channel has a one-entry output register, so per-channel backpressure stalls only the addressed channel.
- Two routing modes:
  - addressed: the destination comes from s_sel;
  - round-robin: an internal pointer picks the destination.
- Sits between a single producer and NUM_CH independent consumers in the datapath.

---
 rtl/stream_demux_1ton.sv | 112 +++++++++++
 tb/tb_stream_demux_1ton.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux_1ton.sv
// Registered 1:N stream demultiplexer with addressed or round-robin routing.
// Each output channel owns a one-entry register so backpressure stays local.
module stream_demux_1ton #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = 2,
    parameter int MODE   = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DATA_W-1:0]        s_data,
    input  logic [SEL_W-1:0]         s_sel,
    output logic [NUM_CH-1:0]        m_valid,
    input  logic [NUM_CH-1:0]        m_ready,
    output logic [NUM_CH*DATA_W-1:0] m_data,
    output logic                     drop_pulse,
    output logic [7:0]               drop_cnt,
    output logic [SEL_W-1:0]         rr_ptr
);

    generate
        if ((2 ** SEL_W) < NUM_CH) begin : g_bad_sel_w
            $error("stream_demux_1ton: SEL_W too narrow for NUM_CH");
        end
    endgenerate

    localparam logic [SEL_W:0]   NUM_CH_L = (SEL_W + 1)'(NUM_CH);
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);

    logic [SEL_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [NUM_CH-1:0]        m_valid_q, m_valid_d;
    logic [NUM_CH*DATA_W-1:0] m_data_q, m_data_d;
    logic                     drop_q, drop_d;
    logic [7:0]               drop_cnt_q, drop_cnt_d;

    logic [SEL_W-1:0] dest;
    logic             in_range;
    logic             dest_full;
    logic             accept;

    // Destination, range check and input handshake (no s_valid -> s_ready path)
    always_comb begin
        dest      = (MODE == 1) ? rr_ptr_q : s_sel;
        in_range  = (MODE == 1) || ({1'b0, s_sel} < NUM_CH_L);
        dest_full = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (dest == SEL_W'(i)) begin
                dest_full = m_valid_q[i] && !m_ready[i];
            end
        end
        s_ready = !in_range || !dest_full;
        accept  = s_valid && s_ready;
    end

    // Per-channel register: drain clears valid, a fill on the same edge wins
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (m_ready[i]) begin
                m_valid_d[i] = 1'b0;
            end
            if (accept && in_range && (dest == SEL_W'(i))) begin
                m_valid_d[i]                = 1'b1;
                m_data_d[i*DATA_W +: DATA_W] = s_data;
            end
        end
    end

    // Out-of-range beats are swallowed and counted (saturating)
    always_comb begin
        drop_d     = accept && !in_range;
        drop_cnt_d = drop_cnt_q;
        if (drop_d && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // Round-robin pointer moves only on an accepted beat
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if ((MODE == 1) && accept) begin
            rr_ptr_d = (rr_ptr_q == LAST_CH) ? '0 : rr_ptr_q + SEL_W'(1);
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            m_valid_q  <= '0;
            m_data_q   <= '0;
            drop_q     <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            drop_q     <= drop_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign drop_pulse = drop_q;
    assign drop_cnt   = drop_cnt_q;
    assign rr_ptr     = rr_ptr_q;

endmodule

// File: tb/tb_stream_demux_1ton.sv
// Directed bench for stream_demux_1ton: addressed 1:4, addressed 1:3 with
// drops, and round-robin 1:3 instances driven from one clock and reset.
module tb_stream_demux_1ton;

    logic clk;
    logic rst_n;

    // addressed, 4 channels
    logic        a_valid, a_ready;
    logic [7:0]  a_data;
    logic [1:0]  a_sel;
    logic [3:0]  a_mv, a_mr;
    logic [31:0] a_md;
    logic        a_dp;
    logic [7:0]  a_dc;
    logic [1:0]  a_rr;

    // addressed, 3 channels
    logic        b_valid, b_ready;
    logic [7:0]  b_data;
    logic [1:0]  b_sel;
    logic [2:0]  b_mv, b_mr;
    logic [23:0] b_md;
    logic        b_dp;
    logic [7:0]  b_dc;
    logic [1:0]  b_rr;

    // round-robin, 3 channels
    logic        c_valid, c_ready;
    logic [7:0]  c_data;
    logic [1:0]  c_sel;
    logic [2:0]  c_mv, c_mr;
    logic [23:0] c_md;
    logic        c_dp;
    logic [7:0]  c_dc;
    logic [1:0]  c_rr;

    int nchk = 0;
    int nerr = 0;

    stream_demux_1ton #(.NUM_CH(4), .DATA_W(8), .SEL_W(2), .MODE(0)) u_a (
        .clk(clk), .rst_n(rst_n),
        .s_valid(a_valid), .s_ready(a_ready), .s_data(a_data), .s_sel(a_sel),
        .m_valid(a_mv), .m_ready(a_mr), .m_data(a_md),
        .drop_pulse(a_dp), .drop_cnt(a_dc), .rr_ptr(a_rr)
    );

    stream_demux_1ton #(.NUM_CH(3), .DATA_W(8), .SEL_W(2), .MODE(0)) u_b (
        .clk(clk), .rst_n(rst_n),
        .s_valid(b_valid), .s_ready(b_ready), .s_data(b_data), .s_sel(b_sel),
        .m_valid(b_mv), .m_ready(b_mr), .m_data(b_md),
        .drop_pulse(b_dp), .drop_cnt(b_dc), .rr_ptr(b_rr)
    );

    stream_demux_1ton #(.NUM_CH(3), .DATA_W(8), .SEL_W(2), .MODE(1)) u_c (
        .clk(clk), .rst_n(rst_n),
        .s_valid(c_valid), .s_ready(c_ready), .s_data(c_data), .s_sel(c_sel),
        .m_valid(c_mv), .m_ready(c_mr), .m_data(c_md),
        .drop_pulse(c_dp), .drop_cnt(c_dc), .rr_ptr(c_rr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        a_valid = 0; a_data = 0; a_sel = 0; a_mr = 4'hF;
        b_valid = 0; b_data = 0; b_sel = 0; b_mr = 3'h7;
        c_valid = 0; c_data = 0; c_sel = 0; c_mr = 3'h7;
        #2;
        chk("rst_a_mv", 32'(a_mv), 0);
        chk("rst_a_md", a_md, 0);
        chk("rst_b_dc", 32'(b_dc), 0);
        chk("rst_b_dp", 32'(b_dp), 0);
        chk("rst_c_rr", 32'(c_rr), 0);
        chk("rst_a_rdy", 32'(a_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // back-to-back addressed beats, all consumers ready
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k > 0) begin
                chk("b2b_mv", 32'(a_mv), 32'(4'b1 << (k - 1)));
                chk("b2b_md", 32'(a_md[(k-1)*8 +: 8]), 32'(8'hA0 + k - 1));
            end
            a_valid = 1; a_sel = 2'(k); a_data = 8'(8'hA0 + k);
            #1 chk("b2b_rdy", 32'(a_ready), 1);
        end
        @(negedge clk);
        chk("b2b_mv3", 32'(a_mv), 32'h8);
        chk("b2b_md3", 32'(a_md[31:24]), 32'hA3);
        a_valid = 0;
        @(negedge clk);
        chk("b2b_idle", 32'(a_mv), 0);

        // per-channel stall on ch2
        a_mr = 4'b1011;
        a_valid = 1; a_sel = 2; a_data = 8'h11;
        #1 chk("st_rdy0", 32'(a_ready), 1);
        @(negedge clk);
        chk("st_mv0", 32'(a_mv), 32'h4);
        chk("st_md0", 32'(a_md[23:16]), 32'h11);
        a_sel = 2; a_data = 8'h22;
        #1 chk("st_rdy1", 32'(a_ready), 0);
        @(negedge clk);
        chk("st_hold_mv", 32'(a_mv), 32'h4);
        chk("st_hold_md", 32'(a_md[23:16]), 32'h11);
        chk("st_rdy2", 32'(a_ready), 0);
        a_mr = 4'hF;
        #1 chk("st_rdy3", 32'(a_ready), 1);
        @(negedge clk);
        chk("st_swap_mv", 32'(a_mv), 32'h4);
        chk("st_swap_md", 32'(a_md[23:16]), 32'h22);
        a_sel = 1; a_data = 8'h33;
        #1 chk("st_rdy4", 32'(a_ready), 1);
        @(negedge clk);
        chk("st_ch1_mv", 32'(a_mv), 32'h2);
        chk("st_ch1_md", 32'(a_md[15:8]), 32'h33);
        chk("st_ch2_hold", 32'(a_md[23:16]), 32'h22);
        a_valid = 0;

        // full throughput on ch0
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k > 0) begin
                chk("thr_mv", 32'(a_mv[0]), 1);
                chk("thr_md", 32'(a_md[7:0]), 32'(8'h80 + k - 1));
            end
            a_valid = 1; a_sel = 0; a_data = 8'(8'h80 + k);
            #1 chk("thr_rdy", 32'(a_ready), 1);
        end
        @(negedge clk);
        chk("thr_last", 32'(a_md[7:0]), 32'h8F);
        a_valid = 0;

        // out-of-range drops with saturation (3 channels, sel=3)
        for (int k = 0; k < 260; k++) begin
            @(negedge clk);
            if (k > 0) begin
                chk("drp_pulse", 32'(b_dp), 1);
                chk("drp_cnt", 32'(b_dc), (k > 255) ? 255 : k);
                chk("drp_mv", 32'(b_mv), 0);
            end
            b_valid = 1; b_sel = 3; b_data = 8'hFF;
            #1 chk("drp_rdy", 32'(b_ready), 1);
        end
        @(negedge clk);
        chk("drp_pulse_l", 32'(b_dp), 1);
        chk("drp_cnt_l", 32'(b_dc), 255);
        b_valid = 0;
        @(negedge clk);
        chk("drp_pulse_0", 32'(b_dp), 0);
        chk("drp_cnt_0", 32'(b_dc), 255);

        // round-robin 0,1,2,0,1,2,0
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk("rr_ptr", 32'(c_rr), k % 3);
            if (k > 0) begin
                chk("rr_mv", 32'(c_mv), 32'(3'b1 << ((k - 1) % 3)));
                chk("rr_md", 32'(c_md[((k-1)%3)*8 +: 8]), 32'(8'hD0 + k - 1));
            end
            c_valid = 1; c_sel = 2'(3 - (k % 3)); c_data = 8'(8'hD0 + k);
        end
        @(negedge clk);
        chk("rr_end_mv", 32'(c_mv), 1);
        chk("rr_end_md", 32'(c_md[7:0]), 32'hD6);
        chk("rr_end_ptr", 32'(c_rr), 1);
        chk("rr_no_drop", 32'(c_dc), 0);

        // strict order: fill ch1 then come back to it while it is stalled
        c_mr = 3'b101;
        c_data = 8'hE1;
        @(negedge clk);
        c_data = 8'hE2;
        @(negedge clk);
        c_data = 8'hE0;
        @(negedge clk);
        chk("rr_full_ptr", 32'(c_rr), 1);
        chk("rr_full_mv", 32'(c_mv), 32'h3);
        c_data = 8'hE4;
        #1 chk("rr_stall_rdy", 32'(c_ready), 0);
        @(negedge clk);
        chk("rr_stall_ptr", 32'(c_rr), 1);
        chk("rr_stall_md", 32'(c_md[15:8]), 32'hE1);
        chk("rr_stall_mv", 32'(c_mv), 32'h2);

        // load state, then asynchronous reset between edges
        c_mr = 3'h7;
        c_data = 8'hE5;
        a_mr = 4'h0;
        a_valid = 1; a_sel = 0; a_data = 8'h5A;
        @(negedge clk);
        a_sel = 3; a_data = 8'hA5;
        c_valid = 0;
        @(negedge clk);
        a_valid = 0;
        chk("pre_a_mv", 32'(a_mv), 32'h9);
        chk("pre_c_rr", 32'(c_rr), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_a_mv", 32'(a_mv), 0);
        chk("arst_a_md", a_md, 0);
        chk("arst_c_mv", 32'(c_mv), 0);
        chk("arst_c_rr", 32'(c_rr), 0);
        chk("arst_b_dc", 32'(b_dc), 0);
        @(negedge clk);
        rst_n = 1'b1;
        a_mr = 4'hF;
        c_valid = 1; c_data = 8'h77;
        #1 chk("post_rdy", 32'(c_ready), 1);
        @(negedge clk);
        c_valid = 0;
        chk("post_mv", 32'(c_mv), 1);
        chk("post_md", 32'(c_md[7:0]), 32'h77);
        chk("post_rr", 32'(c_rr), 1);
        chk("post_b_dc", 32'(b_dc), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
